// File: rtl/issue_stage_pkg.sv
// Shared types for the issue stage: decoded op encoding, default sizes and
// which source operands each op reads.
package issue_stage_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int REG_W    = $clog2(DEF_NREG);

  typedef enum logic [2:0] {
    INSTR_INVAL  = 3'd0,
    INSTR_LUI    = 3'd1,
    INSTR_AUIPC  = 3'd2,
    INSTR_JAL    = 3'd3,
    INSTR_JALR   = 3'd4,
    INSTR_BRANCH = 3'd5,
    INSTR_ALU_R  = 3'd6,
    INSTR_ALU_I  = 3'd7
  } instr_op_t;

  function automatic logic op_uses_rs1(instr_op_t op);
    case (op)
      INSTR_JALR, INSTR_BRANCH, INSTR_ALU_R, INSTR_ALU_I: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs2(instr_op_t op);
    case (op)
      INSTR_BRANCH, INSTR_ALU_R: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-destination tracker: one busy bit per architectural register,
// x0 never busy. Flush wipes everything; set beats clear on the same reg.
module issue_scoreboard #(
  parameter int NREG = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  logic [RW-1:0] rd1_idx,
  input  logic [RW-1:0] rd2_idx,
  output logic          rd1_busy,
  output logic          rd2_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (flush)  busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_d;
  end

  assign rd1_busy = busy[rd1_idx];
  assign rd2_busy = busy[rd2_idx];

endmodule

// File: rtl/issue_stage.sv
// Operand fetch / issue: regfile read with writeback bypass, RAW stall via
// scoreboard, and a single registered valid/ready slot towards exec.
module issue_stage import issue_stage_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  instr_op_t       in_op,
  input  logic [RW-1:0]   in_rd,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  output logic [RW-1:0]   rf_rs1_addr,
  output logic [RW-1:0]   rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic            out_valid,
  input  logic            out_ready,
  output instr_op_t       out_op,
  output logic [RW-1:0]   out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val
);

  typedef struct packed {
    instr_op_t       op;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
  } issue_pkt_t;

  issue_pkt_t pkt_d, pkt_q;
  logic       vld_q;
  logic       wb_hit1, wb_hit2;
  logic       busy1, busy2;
  logic       hazard, fire;

  assign rf_rs1_addr = in_rs1;
  assign rf_rs2_addr = in_rs2;

  assign wb_hit1 = wb_valid && (wb_rd == in_rs1);
  assign wb_hit2 = wb_valid && (wb_rd == in_rs2);

  always_comb begin
    pkt_d.op      = in_op;
    pkt_d.rd      = in_rd;
    pkt_d.imm     = in_imm;
    pkt_d.pc      = in_pc;
    pkt_d.rs1_val = (in_rs1 == '0) ? '0 : (wb_hit1 ? wb_val : rf_rs1_data);
    pkt_d.rs2_val = (in_rs2 == '0) ? '0 : (wb_hit2 ? wb_val : rf_rs2_data);
  end

  // A producer writing back this very cycle is not a hazard: the bypass covers it.
  assign hazard = (op_uses_rs1(in_op) && (in_rs1 != '0) && busy1 && !wb_hit1) ||
                  (op_uses_rs2(in_op) && (in_rs2 != '0) && busy2 && !wb_hit2);

  assign in_ready = !flush && !hazard && (!vld_q || out_ready);
  assign fire     = in_valid && in_ready;

  issue_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (fire && (in_rd != '0) && (in_op != INSTR_INVAL)),
    .set_idx  (in_rd),
    .clr_en   (wb_valid && (wb_rd != '0)),
    .clr_idx  (wb_rd),
    .rd1_idx  (in_rs1),
    .rd2_idx  (in_rs2),
    .rd1_busy (busy1),
    .rd2_busy (busy2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      pkt_q <= '0;
    end else if (fire) begin
      vld_q <= 1'b1;
      pkt_q <= pkt_d;
    end else if (flush || out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid   = vld_q;
  assign out_op      = pkt_q.op;
  assign out_rd      = pkt_q.rd;
  assign out_imm     = pkt_q.imm;
  assign out_pc      = pkt_q.pc;
  assign out_rs1_val = pkt_q.rs1_val;
  assign out_rs2_val = pkt_q.rs2_val;

endmodule
